// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480 timing constants and framebuffer address helpers
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int X_BITS        = 10;
  localparam int Y_BITS        = 9;
  localparam int PIX_ADDR_BITS = X_BITS + Y_BITS;

  typedef logic [PIX_ADDR_BITS-1:0] pix_addr_t;

  function automatic pix_addr_t pix_addr(input logic [Y_BITS-1:0] y,
                                         input logic [X_BITS-1:0] x);
    return {y, x};
  endfunction
endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - 1-bit simple dual-port framebuffer, registered read, read-old-data on collision
module frame_buffer
  import vga_pkg::*;
(
  input  logic      clk,
  input  logic      wr_en,
  input  pix_addr_t wr_addr,
  input  logic      wr_data,
  input  pix_addr_t rd_addr,
  output logic      rd_data
);
  logic mem [0:(1<<PIX_ADDR_BITS)-1];
  logic rd_data_q;

  // Non-blocking read and write in one block gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - pixel writes into a 1-bit framebuffer, scanned out as a VGA raster
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [10:0] wr_x,
  input  logic [10:0] wr_y,
  input  logic        wr_color,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        pixel_on,
  output logic        in_vblank,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic             blank_n_q, blank_n_d, pixel_on_q, pixel_on_d;
  logic             in_vblank_q, in_vblank_d, frame_start_q, frame_start_d;
  logic             tick, visible, wr_ok, rd_data;

  assign wr_ok = wr_en && (wr_x < H_VIS) && (wr_y < V_VIS);

  frame_buffer u_fb (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (pix_addr(wr_y[Y_BITS-1:0], wr_x[X_BITS-1:0])),
    .wr_data (wr_color),
    .rd_addr (pix_addr(vcnt_q[Y_BITS-1:0], hcnt_q[X_BITS-1:0])),
    .rd_data (rd_data)
  );

  always_comb begin
    tick    = (div_q == DIV_LAST);
    visible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    div_d   = tick ? '0 : div_q + 1'b1;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end
  end

  // Output stage samples the position the counters hold during the pixel period that tick ends.
  always_comb begin
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    blank_n_d     = blank_n_q;
    pixel_on_d    = pixel_on_q;
    in_vblank_d   = in_vblank_q;
    frame_start_d = 1'b0;
    if (tick) begin
      hsync_n_d     = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
      vsync_n_d     = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
      blank_n_d     = visible;
      pixel_on_d    = visible && rd_data;
      in_vblank_d   = (vcnt_q >= V_VIS);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      pixel_on_q    <= 1'b0;
      in_vblank_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      blank_n_q     <= blank_n_d;
      pixel_on_q    <= pixel_on_d;
      in_vblank_q   <= in_vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank_n     = blank_n_q;
  assign pixel_on    = pixel_on_q;
  assign in_vblank   = in_vblank_q;
  assign frame_start = frame_start_q;
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the pixel-write path. Accepts the `(x, y, color)` pixel writes produced by the display manager into a 1-bit framebuffer. Continuously scans that framebuffer out as a 640×480 VGA raster with sync, blanking and a 1-bit video signal. It also gives game logic a vblank indication and a frame-start pulse, so screen clears and object updates can be gated to the retrace interval.

## Interface
Parameters:
- `CLK_DIV`, 2, system clocks per pixel; must be ≥ 2.
- `H_ACTIVE`, 640, visible pixels per line.
- `H_FP`, 16, horizontal front porch in pixels.
- `H_SYNC`, 96, hsync width in pixels.
- `H_BP`, 48, horizontal back porch in pixels.
- `V_ACTIVE`, 480, visible lines.
- `V_FP`, 10, vertical front porch in lines.
- `V_SYNC`, 2, vsync width in lines.
- `V_BP`, 33, vertical back porch in lines.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  pixel write strobe.
- `wr_x`  in  11  write column.
- `wr_y`  in  11  write row.
- `wr_color`  in  1  pixel value to store; 1 = lit.
- `hsync_n`  out  1  horizontal sync, active-low.
- `vsync_n`  out  1  vertical sync, active-low.
- `blank_n`  out  1  high in the visible region.
- `pixel_on`  out  1  video bit, forced to 0 outside the visible region.
- `in_vblank`  out  1  high while the output line ≥ `V_ACTIVE`.
- `frame_start`  out  1  one-clk pulse when position (0,0) reaches the outputs.

## Operation
Divider and counters:
- The divider `div` counts 0..`CLK_DIV`−1. `tick` = (`div` == `CLK_DIV`−1).
- On `tick`, `hcnt` advances 0..H_TOTAL−1, where H_TOTAL = 800.
- `vcnt` advances 0..V_TOTAL−1 (V_TOTAL = 525) on `tick` when `hcnt` wraps. Both counters wrap to 0.

Framebuffer:
- Size 2^19 × 1 bit, address `{y[8:0], x[9:0]}`. Contents are not reset.
- Write: on any clk with `wr_en`=1, `wr_x` < `H_ACTIVE` and `wr_y` < `V_ACTIVE`, `mem[{wr_y,wr_x}]` ← `wr_color`.
- Out-of-range writes are silently dropped.

Read:
- The read address is `{vcnt[8:0], hcnt[9:0]}` every clk. Read data is registered, so it is valid one clk later.
- Read and write to the same address on the same clk: read returns the old data and the write lands.

Output stage (registered, loads only on `tick`), from the current `hcnt`/`vcnt`:
- `hsync_n` = !(656 ≤ h < 752).
- `vsync_n` = !(490 ≤ v < 492).
- `blank_n` = (h < 640) & (v < 480).
- `pixel_on` = `blank_n` & rd_data.
- `in_vblank` = (v ≥ 480).
- `frame_start` = (h == 0 & v == 0) on a `tick` clk; it is 0 on every non-tick clk.

## Timing
- Reset values: `div`=0, `hcnt`=0, `vcnt`=0, `hsync_n`=1, `vsync_n`=1, `blank_n`=0, `pixel_on`=0, `in_vblank`=0, `frame_start`=0.
- The first `tick` is `CLK_DIV` clks after `reset` deasserts. It loads position (0,0) and pulses `frame_start`.
- Latency: outputs for (h,v) appear on the clk after the `tick` ending that pixel period. All outputs stay aligned with each other.
- `CLK_DIV` ≥ 2 guarantees read data is valid before `tick`.
- Frame length is exactly `CLK_DIV`×800×525 clks.
- A write is visible to any scan read issued on a later clk, including in the same frame.
- Reset asserted mid-frame: counters and outputs return to their reset values on the next clk edge. Framebuffer contents are preserved.

## Structure
- Package `vga_pkg` holds:
  - the timing constants (active/porch/sync/total, H and V);
  - `X_BITS`=10 and `Y_BITS`=9;
  - a `pix_addr_t` typedef.
- Sub-module `frame_buffer`: simple dual-port RAM with one write port and one registered read port, read-old-data on collision, inferable as block RAM.
- Counters, divider and the output stage live in `vga_scanout`.

## Test plan
- **Reset:** hold `reset` 3 clks, release.
  - All outputs hold their reset values until the first `tick`.
  - `frame_start` pulses `CLK_DIV` clks after release.
- **Line/frame timing:** run 2 frames with `CLK_DIV`=2.
  - `hsync_n` is low for exactly 192 clks per 1600-clk line.
  - `vsync_n` is low for exactly 2 lines.
  - `frame_start` pulses are exactly 840000 clks apart.
- **Write/readback:** write (x=100, y=380, color=1) and (x=639, y=479, color=1), with the rest of the framebuffer set to 0.
  - `pixel_on`=1 only at the output positions (100,380) and (639,479).
  - Everything else, including the blanking region, reads 0.
- **Range check:** write color=1 at (640,0), (0,480) and (2047,2047).
  - No lit pixel appears anywhere.
  - (0,0) and (0,0)+wrap addresses are unchanged.
- **Collision:** write color=1 to (5,5) on the exact clk the read address equals (5,5).
  - The current frame shows 0 at (5,5).
  - The next frame shows 1.
- **Mid-frame reset:** assert `reset` at line 200.
  - Outputs go to reset values on the next clk.
  - After release, `frame_start` pulses after `CLK_DIV` clks.
  - Previously written pixels still display.
